// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result is computed when the operation is accepted and commits after a fixed busy latency.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  MDUop,
  input  logic [31:0] MDU_in1,
  input  logic [31:0] MDU_in2,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDU_out
);

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_MULT = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV  = 4'd3,
    OP_DIVU = 4'd4,
    OP_MFHI = 4'd5,
    OP_MFLO = 4'd6,
    OP_MTHI = 4'd7,
    OP_MTLO = 4'd8
  } mdu_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  typedef logic [CNT_W-1:0] cnt_t;

  state_e      state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        commit_q, commit_d;
  logic [63:0] result_q, result_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Datapath: operands are consumed only on the accepting edge.
  logic [63:0] a_sx, b_sx, prod_s, prod_u;
  logic        div_signed, neg_a, neg_b, div_by_zero;
  logic [31:0] mag_a, mag_b, uq, ur, quot, rem;

  always_comb begin
    a_sx   = {{32{MDU_in1[31]}}, MDU_in1};
    b_sx   = {{32{MDU_in2[31]}}, MDU_in2};
    prod_s = a_sx * b_sx;
    prod_u = {32'd0, MDU_in1} * {32'd0, MDU_in2};

    // Divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 instead of overflowing.
    div_signed  = (MDUop == OP_DIV);
    neg_a       = div_signed & MDU_in1[31];
    neg_b       = div_signed & MDU_in2[31];
    div_by_zero = (MDU_in2 == 32'd0);
    mag_a       = neg_a ? (~MDU_in1 + 32'd1) : MDU_in1;
    mag_b       = neg_b ? (~MDU_in2 + 32'd1) : MDU_in2;
    if (div_by_zero) mag_b = 32'd1;
    uq   = mag_a / mag_b;
    ur   = mag_a % mag_b;
    quot = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
    rem  = neg_a ? (~ur + 32'd1) : ur;
  end

  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no branch can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    commit_d = commit_q;
    result_d = result_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          unique case (MDUop)
            OP_MULT, OP_MULTU: begin
              result_d = (MDUop == OP_MULT) ? prod_s : prod_u;
              commit_d = 1'b1;
              cnt_d    = cnt_t'(MULT_CYCLES);
              busy_d   = 1'b1;
              state_d  = S_RUN;
            end
            OP_DIV, OP_DIVU: begin
              result_d = {rem, quot};
              commit_d = ~div_by_zero;
              cnt_d    = cnt_t'(DIV_CYCLES);
              busy_d   = 1'b1;
              state_d  = S_RUN;
            end
            OP_MTHI: hi_d = MDU_in1;
            OP_MTLO: lo_d = MDU_in1;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - cnt_t'(1);
        if (cnt_q == cnt_t'(1)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          if (commit_q) begin
            hi_d = result_q[63:32];
            lo_d = result_q[31:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      commit_q <= 1'b0;
      result_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      commit_q <= commit_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  always_comb begin
    MDU_out = 32'd0;
    if (MDUop == OP_MFHI) MDU_out = hi_q;
    else if (MDUop == OP_MFLO) MDU_out = lo_q;
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: vector table plus scoreboard, and hand sequences for busy/reset corners.
module tb_mdu;

  localparam int MC = 5;
  localparam int DC = 10;
  localparam logic [3:0] MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3, DIVU = 4'd4;
  localparam logic [3:0] MFHI = 4'd5, MFLO = 4'd6, MTHI = 4'd7, MTLO = 4'd8;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [3:0]  MDUop;
  logic [31:0] MDU_in1, MDU_in2;
  logic        busy;
  logic [31:0] HI, LO, MDU_out;

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .MDUop(MDUop),
    .MDU_in1(MDU_in1), .MDU_in2(MDU_in2),
    .busy(busy), .HI(HI), .LO(LO), .MDU_out(MDU_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  typedef struct {
    logic [31:0] hi, lo;
  } res_t;

  res_t sb_q[$];
  vec_t vecs[9];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic res_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, up;
    res_t            r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = '{hi: 32'd0, lo: 32'd0};
    case (op)
      MULT:  begin sq = sa * sb; r.hi = sq[63:32]; r.lo = sq[31:0]; end
      MULTU: begin up = ua * ub; r.hi = up[63:32]; r.lo = up[31:0]; end
      DIV:   begin sq = sa / sb; sr = sa % sb; r.hi = sr[31:0]; r.lo = sq[31:0]; end
      DIVU:  begin up = ua / ub; r.lo = up[31:0]; up = ua % ub; r.hi = up[31:0]; end
      default: ;
    endcase
    return r;
  endfunction

  // Drive one start pulse sampled on the next rising edge, then scramble operands.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; MDUop = op; MDU_in1 = a; MDU_in2 = b;
    @(posedge clk);
    #1;
    start = 1'b0; MDUop = 4'd0; MDU_in1 = $urandom; MDU_in2 = $urandom;
  endtask

  task automatic wait_done(input string name, input int lat);
    int cnt = 0;
    bit done = 1'b0;
    for (int g = 0; g < 200 && !done; g++) begin
      @(negedge clk);
      if (busy) cnt++;
      else done = 1'b1;
    end
    check({name, " busy cycles"}, 32'(cnt), 32'(lat));
  endtask

  task automatic compare_result(input string name);
    res_t r;
    if (sb_q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s: scoreboard empty, got HI=%h LO=%h", name, HI, LO);
    end else begin
      r = sb_q.pop_front();
      check({name, " HI"}, HI, r.hi);
      check({name, " LO"}, LO, r.lo);
    end
  endtask

  initial begin
    res_t        m;
    logic [31:0] last_lo;
    int          lat;

    reset = 1'b1; start = 1'b0; MDUop = 4'd0; MDU_in1 = '0; MDU_in2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset HI", HI, 32'd0);
    check("reset LO", LO, 32'd0);

    vecs[0] = '{op: MULT,  a: 32'hFFFFFFFF, b: 32'h00000002, hi: 32'hFFFFFFFF, lo: 32'hFFFFFFFE};
    vecs[1] = '{op: MULTU, a: 32'hFFFFFFFF, b: 32'h00000002, hi: 32'h00000001, lo: 32'hFFFFFFFE};
    vecs[2] = '{op: DIV,   a: 32'hFFFFFFF9, b: 32'h00000002, hi: 32'hFFFFFFFF, lo: 32'hFFFFFFFD};
    vecs[3] = '{op: DIVU,  a: 32'hFFFFFFF9, b: 32'h00000002, hi: 32'h00000001, lo: 32'h7FFFFFFC};
    vecs[4] = '{op: DIV,   a: 32'h80000000, b: 32'hFFFFFFFF, hi: 32'h00000000, lo: 32'h80000000};
    for (int i = 5; i < 9; i++) begin
      vecs[i].op = 4'(1 + (i % 4));
      vecs[i].a  = $urandom;
      vecs[i].b  = $urandom | 32'h00000100;
      m = model(vecs[i].op, vecs[i].a, vecs[i].b);
      vecs[i].hi = m.hi;
      vecs[i].lo = m.lo;
    end

    for (int i = 0; i < 9; i++) begin
      lat = (vecs[i].op == MULT || vecs[i].op == MULTU) ? MC : DC;
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      sb_q.push_back('{hi: vecs[i].hi, lo: vecs[i].lo});
      wait_done($sformatf("vec%0d", i), lat);
      compare_result($sformatf("vec%0d", i));
      if (i == 0) begin
        MDUop = MFHI; #1; check("mfhi out", MDU_out, 32'hFFFFFFFF);
        MDUop = MFLO; #1; check("mflo out", MDU_out, 32'hFFFFFFFE);
        MDUop = 4'd9; #1; check("op9 out", MDU_out, 32'd0);
        MDUop = 4'd0;
      end
    end
    last_lo = vecs[8].lo;

    // mthi, then divide by zero leaves HI/LO untouched
    issue(MTHI, 32'h12345678, 32'd0);
    check("mthi HI", HI, 32'h12345678);
    check("mthi busy", {31'd0, busy}, 32'd0);
    issue(DIVU, 32'd5, 32'd0);
    sb_q.push_back('{hi: 32'h12345678, lo: last_lo});
    wait_done("div0", DC);
    compare_result("div0");

    // starts while busy are ignored; start at E+L ignored, at E+L+1 accepted
    issue(DIV, 32'd100, 32'd7);
    check("div busy rise", {31'd0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b1; MDUop = MULT; MDU_in1 = 32'd3; MDU_in2 = 32'd3;
    @(posedge clk);
    @(negedge clk);
    MDUop = MTLO; MDU_in1 = 32'h0000DEAD;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (DC - 3) @(posedge clk);
    #1;
    check("busy at E+L-1", {31'd0, busy}, 32'd1);
    check("LO before commit", LO, last_lo);
    @(negedge clk);
    start = 1'b1; MDUop = MTLO; MDU_in1 = 32'h0000BEEF;
    @(posedge clk);
    #1;
    check("busy after E+L", {31'd0, busy}, 32'd0);
    check("div HI at E+L", HI, 32'd2);
    check("div LO at E+L", LO, 32'd14);
    @(posedge clk);
    #1 start = 1'b0; MDUop = 4'd0;
    check("mtlo at E+L+1", LO, 32'h0000BEEF);
    check("HI after mtlo", HI, 32'd2);

    // reset in the third busy cycle aborts the mult
    issue(MULT, 32'd3, 32'd4);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("abort busy", {31'd0, busy}, 32'd0);
    check("abort HI", HI, 32'd0);
    check("abort LO", LO, 32'd0);
    repeat (MC + 3) @(posedge clk);
    #1;
    check("no late commit LO", LO, 32'd0);
    check("no late busy", {31'd0, busy}, 32'd0);

    // reset wins over start on the same edge
    @(negedge clk);
    reset = 1'b1; start = 1'b1; MDUop = MTHI; MDU_in1 = 32'h55;
    @(posedge clk);
    #1;
    MDUop = MULT;
    @(posedge clk);
    #1 reset = 1'b0; start = 1'b0; MDUop = 4'd0;
    check("reset+mthi HI", HI, 32'd0);
    check("reset+mult busy", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
